// File: rtl/cpl_packer.sv
// cpl_packer: packs 64-bit read-completion beats (1-2 DWs) into 128-bit words per tag. Ports: i_clk/i_rst_n (async active-low), in_* beat input with in_ready, packer_* registered output bus (tag, dout, dwen, valid, done); err_flags[1:0] only with CPL_PACKER_ERR_EN.
module cpl_packer #(
  parameter int p_tag_width = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [p_tag_width-1:0] in_tag,
  input  logic [63:0]            in_data,
  input  logic [1:0]             in_dwen,
  input  logic                   in_last,
  input  logic                   in_final,
  output logic [p_tag_width-1:0] packer_tag,
  output logic [127:0]           packer_dout,
  output logic [3:0]             packer_dout_dwen,
  output logic                   packer_valid,
  output logic                   packer_done
`ifdef CPL_PACKER_ERR_EN
  ,
  output logic [1:0]             err_flags
`endif
);
  typedef enum logic [1:0] {S_RST, S_RUN, S_FLUSH} state_t;
  state_t state, state_nx;
  logic [95:0] acc, acc_nx;
  logic [1:0] cnt, cnt_nx, n;
  logic [p_tag_width-1:0] tag, tag_nx, ptag_nx, eff_tag;
  logic carry, carry_nx;
  logic [127:0] dout_nx;
  logic [3:0] dwen_nx;
  logic valid_nx, done_nx, fire;
  logic [2:0] total;
  logic [63:0] din;
  logic [159:0] comb;
  assign in_ready = state == S_RUN;
  assign fire = in_valid && in_ready;
  // 2'b10 carries no data
  assign n = in_dwen == 2'b11 ? 2'd2 : in_dwen == 2'b01 ? 2'd1 : 2'd0;
  assign din = in_dwen == 2'b11 ? in_data : in_dwen == 2'b01 ? {32'd0, in_data[31:0]} : 64'd0;
  assign total = {1'b0, cnt} + {1'b0, n};
  // unused acc slots are kept zero so OR-merging places the new DWs at slot cnt
  assign comb = {64'd0, acc} | ({96'd0, din} << {cnt, 5'd0});
  assign eff_tag = cnt == 2'd0 ? in_tag : tag;
  always_comb begin
    state_nx = S_RUN;
    acc_nx = acc;
    cnt_nx = cnt;
    tag_nx = tag;
    carry_nx = carry;
    ptag_nx = packer_tag;
    dout_nx = packer_dout;
    dwen_nx = packer_dout_dwen;
    valid_nx = 1'b0;
    done_nx = 1'b0;
    if (state == S_FLUSH) begin
      valid_nx = 1'b1;
      done_nx = carry;
      ptag_nx = tag;
      dout_nx = {96'd0, acc[31:0]};
      dwen_nx = 4'h1;
      acc_nx = '0;
      cnt_nx = 2'd0;
    end else if (fire) begin
      tag_nx = eff_tag;
      ptag_nx = eff_tag;
      if (total >= 3'd4) begin
        valid_nx = 1'b1;
        dout_nx = comb[127:0];
        dwen_nx = 4'hF;
        acc_nx = {64'd0, comb[159:128]};
        cnt_nx = {1'b0, total[0]};
        if (in_last && total[0]) begin
          state_nx = S_FLUSH;
          carry_nx = in_final;
        end else done_nx = in_last && in_final;
      end else if (in_last) begin
        valid_nx = total != 3'd0;
        done_nx = in_final;
        dout_nx = total != 3'd0 ? comb[127:0] : packer_dout;
        dwen_nx = total != 3'd0 ? (4'd1 << total) - 4'd1 : packer_dout_dwen;
        acc_nx = '0;
        cnt_nx = 2'd0;
      end else begin
        acc_nx = comb[95:0];
        cnt_nx = total[1:0];
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= S_RST;
      acc <= '0;
      cnt <= 2'd0;
      tag <= '0;
      carry <= 1'b0;
      packer_tag <= '0;
      packer_dout <= '0;
      packer_dout_dwen <= 4'h0;
      packer_valid <= 1'b0;
      packer_done <= 1'b0;
    end else begin
      state <= state_nx;
      acc <= acc_nx;
      cnt <= cnt_nx;
      tag <= tag_nx;
      carry <= carry_nx;
      packer_tag <= ptag_nx;
      packer_dout <= dout_nx;
      packer_dout_dwen <= dwen_nx;
      packer_valid <= valid_nx;
      packer_done <= done_nx;
    end
`ifdef CPL_PACKER_ERR_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) err_flags <= 2'b00;
    else if (fire) err_flags <= err_flags | {cnt != 2'd0 && in_tag != tag, in_dwen == 2'b10};
`endif
endmodule

// File: tb/tb_cpl_packer.sv
// tb_cpl_packer: randomized scoreboard bench for cpl_packer against a DW-queue reference model
module tb_cpl_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0, in_ready, in_last = 1'b0, in_final = 1'b0;
  logic [7:0] in_tag = '0, packer_tag;
  logic [63:0] in_data = '0;
  logic [1:0] in_dwen = '0;
  logic [127:0] packer_dout;
  logic [3:0] packer_dout_dwen;
  logic packer_valid, packer_done;
`ifdef CPL_PACKER_ERR_EN
  logic [1:0] err_flags;
`endif
  always #5 clk = ~clk;
  cpl_packer #(.p_tag_width(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .in_data(in_data), .in_dwen(in_dwen), .in_last(in_last),
    .in_final(in_final), .packer_tag(packer_tag), .packer_dout(packer_dout),
    .packer_dout_dwen(packer_dout_dwen), .packer_valid(packer_valid), .packer_done(packer_done)
`ifdef CPL_PACKER_ERR_EN
    , .err_flags(err_flags)
`endif
  );
  typedef struct {
    logic [7:0] tag;
    logic [127:0] dout;
    logic [3:0] dwen;
    logic valid;
    logic done;
  } exp_t;
  exp_t sb[$];
  logic [31:0] dwq[$];
  logic [7:0] cur_tag = '0;
  logic flush_next = 1'b0;
  logic [1:0] exp_err = 2'b00;
  int compared = 0, mismatched = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  always @(negedge clk)
    if (rst_n && (packer_valid || packer_done)) begin
      if (sb.size() == 0) chk("unexpected_output", {126'd0, packer_valid, packer_done}, 128'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("packer_valid", packer_valid, e.valid);
        chk("packer_done", packer_done, e.done);
        if (e.valid) begin
          chk("packer_tag", packer_tag, e.tag);
          chk("packer_dout", packer_dout, e.dout);
          chk("packer_dwen", packer_dout_dwen, e.dwen);
        end
      end
    end
  // Reference: DWs of the open completion form a FIFO; every 4 become a word, in_last drains the rest.
  task automatic model(input logic [7:0] t, input logic [63:0] d, input logic [1:0] dw, input logic last, input logic fin);
    int k = 0;
    int m;
    exp_t e;
    if (dwq.size() == 0) cur_tag = t;
    else if (t != cur_tag) exp_err[1] = 1'b1;
    if (dw == 2'b10) exp_err[0] = 1'b1;
    if (dw[0]) dwq.push_back(d[31:0]);
    if (dw == 2'b11) dwq.push_back(d[63:32]);
    while (dwq.size() >= 4) begin
      e.tag = cur_tag; e.dout = '0; e.dwen = 4'hF; e.valid = 1'b1; e.done = 1'b0;
      for (int i = 0; i < 4; i++) e.dout[32*i +: 32] = dwq.pop_front();
      sb.push_back(e);
      k++;
    end
    if (last) begin
      m = dwq.size();
      e.tag = cur_tag; e.dout = '0; e.dwen = 4'h0; e.valid = m > 0; e.done = fin;
      for (int i = 0; i < m; i++) begin
        e.dout[32*i +: 32] = dwq.pop_front();
        e.dwen[i] = 1'b1;
      end
      if (m > 0) begin
        sb.push_back(e);
        if (k > 0) flush_next = 1'b1;
      end else if (k > 0) sb[sb.size()-1].done = fin;
      else if (fin) sb.push_back(e);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    chk("in_ready", in_ready, !flush_next);
    flush_next = 1'b0;
  endtask
  task automatic send(input logic [7:0] t, input logic [63:0] d, input logic [1:0] dw, input logic last, input logic fin);
    in_valid = 1'b1; in_tag = t; in_data = d; in_dwen = dw; in_last = last; in_final = fin;
    for (int w = 0; ; w++) begin
      cyc();
      if (in_ready) break;
      if (w > 10) begin
        chk("ready_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    @(posedge clk);
    model(t, d, dw, last, fin);
    #1 in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      cyc();
      @(posedge clk); #1;
    end
  endtask
  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", in_ready, 1'b0);
      chk("rst_valid", packer_valid, 1'b0);
      chk("rst_done", packer_done, 1'b0);
      chk("rst_dout", packer_dout, 128'd0);
      chk("rst_dwen", packer_dout_dwen, 4'h0);
      chk("rst_tag", packer_tag, 8'h00);
    end
    dwq.delete();
    flush_next = 1'b0;
    exp_err = 2'b00;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_at_release", in_ready, 1'b0);
    @(posedge clk); #1;
  endtask
  function automatic logic [1:0] rnd_dwen();
    int r = $urandom_range(0, 9);
    return r == 0 ? 2'b00 : r == 1 ? 2'b10 : r < 5 ? 2'b01 : 2'b11;
  endfunction
  initial begin
    #1;
    do_reset();
    for (int i = 0; i < 4; i++) send(8'h05, {$urandom, $urandom}, 2'b11, i == 3, 1'b1);
    idle(2);
    send(8'h11, {$urandom, $urandom}, 2'b01, 1'b0, 1'b0);
    send(8'h11, {$urandom, $urandom}, 2'b11, 1'b0, 1'b0);
    send(8'h11, {$urandom, $urandom}, 2'b11, 1'b1, 1'b1);
    idle(3);
    send(8'h22, 64'h12345678_DEADBEEF, 2'b01, 1'b1, 1'b0);
    idle(2);
    send(8'h33, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b1, 1'b1);
    idle(2);
    send(8'h44, {$urandom, $urandom}, 2'b11, 1'b0, 1'b0);
    send(8'h44, {$urandom, $urandom}, 2'b01, 1'b0, 1'b0);
    idle(1);
    do_reset();
    send(8'h55, 64'hAAAA_AAAA_BBBB_BBBB, 2'b11, 1'b1, 1'b1);
    idle(2);
    for (int c = 0; c < 150; c++) begin
      logic [7:0] t = 8'($urandom);
      int nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        send(t, {$urandom, $urandom}, rnd_dwen(), b == nb - 1, 1'($urandom));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    idle(4);
`ifdef CPL_PACKER_ERR_EN
    chk("err_flags", err_flags, exp_err);
    send(8'h66, {$urandom, $urandom}, 2'b01, 1'b0, 1'b0);
    send(8'h67, {$urandom, $urandom}, 2'b11, 1'b1, 1'b1);
    idle(3);
    chk("err_flags_interleave", err_flags, exp_err);
`endif
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
